// File: rtl/sd_spi_card_model.sv
// rtl/sd_spi_card_model.sv - SPI-mode SD card slave: init sequence plus CMD17 block read from byte memory
// Optional: define SD_MODEL_CRC16_EN to send a real CRC16-CCITT after the data block.
module sd_spi_card_model #(
  parameter int ADDR_W     = 20,
  parameter int NCR        = 1,
  parameter int NAC        = 2,
  parameter int IDLE_POLLS = 2,
  parameter int SDHC       = 1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_spi_cs,
  input  logic              i_spi_sclk,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [7:0]        i_mem_data,
  output logic              o_card_ready,
  output logic              o_cmd_strobe,
  output logic [5:0]        o_cmd_index
);
  localparam int         BLK_W    = ADDR_W - 9;
  localparam logic [9:0] NCR_L    = 10'(NCR);
  localparam logic [9:0] NAC_L    = 10'(NAC);
  localparam logic [7:0] POLL_MAX = 8'(IDLE_POLLS);

  typedef enum logic [3:0] {
    S_HUNT, S_ARG, S_CRC, S_WAIT, S_RESP, S_GAP, S_TOKEN, S_DATA, S_CRC16
  } state_t;

  state_t r_state, w_state_next;

  logic [1:0]       r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic             r_sclk_prev;
  logic [2:0]       r_bit_cnt;
  logic [6:0]       r_rx;
  logic [7:0]       r_tx, r_hold;
  logic [9:0]       r_cnt;
  logic [5:0]       r_idx;
  logic [31:0]      r_arg, r_trail;
  logic [2:0]       r_trail_n;
  logic [7:0]       r_r1;
  logic             r_data_go;
  logic [BLK_W-1:0] r_blk;
  logic             r_idle, r_app;
  logic [7:0]       r_polls;

  logic             w_rise, w_fall, w_cs_hi, w_boundary;
  logic [7:0]       w_rx_byte;
  logic [31:0]      w_blk_full;
  logic             w_blk_oob;
  logic [7:0]       w_r1;
  logic [31:0]      w_trail;
  logic [2:0]       w_trail_n;
  logic             w_data_go, w_idle_nx, w_ready_nx, w_app_nx;
  logic [7:0]       w_polls_nx;
  logic [9:0]       w_cnt_next;
  logic [7:0]       w_tx_load;
  logic             w_rd_go, w_strobe, w_resp_shift;
  logic [8:0]       w_rd_idx;
  logic [7:0]       w_crc_hi, w_crc_lo;

  assign w_cs_hi    = r_cs_sync[1];
  assign w_rise     = r_sclk_sync[1] & ~r_sclk_prev;
  assign w_fall     = ~r_sclk_sync[1] & r_sclk_prev;
  assign w_rx_byte  = {r_rx, r_mosi_sync[1]};
  assign w_boundary = w_rise & (r_bit_cnt == 3'd7) & ~w_cs_hi;
  assign o_spi_miso = w_cs_hi | r_tx[7];

  assign w_blk_full = (SDHC != 0) ? r_arg : {9'd0, r_arg[31:9]};
  assign w_blk_oob  = (w_blk_full >> BLK_W) != 32'd0;

  // Command decode; only consumed on the CRC byte boundary
  always_comb begin
    w_r1       = {7'd0, r_idle};
    w_trail    = 32'hFFFF_FFFF;
    w_trail_n  = 3'd0;
    w_data_go  = 1'b0;
    w_idle_nx  = r_idle;
    w_ready_nx = o_card_ready;
    w_polls_nx = r_polls;
    w_app_nx   = 1'b0;
    case (r_idx)
      6'd0: begin
        w_idle_nx  = 1'b1;
        w_ready_nx = 1'b0;
        w_polls_nx = 8'd0;
        w_r1       = 8'h01;
      end
      6'd8: begin
        w_trail   = {16'h0000, 4'h0, r_arg[11:8], r_arg[7:0]};
        w_trail_n = 3'd4;
      end
      6'd55: w_app_nx = 1'b1;
      6'd41: begin
        if (!r_app) begin
          w_r1 = 8'h04 | {7'd0, r_idle};
        end else if (r_polls < POLL_MAX) begin
          w_r1       = 8'h01;
          w_polls_nx = r_polls + 8'd1;
        end else begin
          w_idle_nx  = 1'b0;
          w_ready_nx = 1'b1;
          w_r1       = 8'h00;
        end
      end
      6'd58: begin
        w_trail   = (SDHC != 0) ? 32'hC0FF_8000 : 32'h80FF_8000;
        w_trail_n = 3'd4;
      end
      6'd17: begin
        if (r_idle)         w_r1 = 8'h05;
        else if (w_blk_oob) w_r1 = 8'h20;
        else                w_data_go = 1'b1;
      end
      default: w_r1 = 8'h04 | {7'd0, r_idle};
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)   r_state <= S_HUNT;
    else if (w_cs_hi) r_state <= S_HUNT;
    else              r_state <= w_state_next;
  end

  // Byte-slot sequencer: each boundary picks the byte for the next slot
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_tx_load    = 8'hFF;
    w_rd_go      = 1'b0;
    w_rd_idx     = 9'd0;
    w_strobe     = 1'b0;
    w_resp_shift = 1'b0;
    if (w_boundary) begin
      case (r_state)
        S_HUNT: begin
          if (w_rx_byte[7:6] == 2'b01) begin
            w_state_next = S_ARG;
            w_cnt_next   = 10'd0;
          end
        end
        S_ARG: begin
          w_cnt_next = r_cnt + 10'd1;
          if (r_cnt == 10'd3) w_state_next = S_CRC;
        end
        S_CRC: begin
          w_strobe     = 1'b1;
          w_state_next = S_WAIT;
          w_cnt_next   = 10'd1;
        end
        S_WAIT: begin
          if (r_cnt < NCR_L) begin
            w_cnt_next = r_cnt + 10'd1;
          end else begin
            w_tx_load    = r_r1;
            w_state_next = S_RESP;
            w_cnt_next   = 10'd0;
          end
        end
        S_RESP: begin
          if (r_cnt < {7'd0, r_trail_n}) begin
            w_tx_load    = r_trail[31:24];
            w_resp_shift = 1'b1;
            w_cnt_next   = r_cnt + 10'd1;
          end else if (!r_data_go) begin
            w_state_next = S_HUNT;
          end else if (NAC_L != 10'd0) begin
            w_state_next = S_GAP;
            w_cnt_next   = 10'd1;
          end else begin
            w_state_next = S_TOKEN;
            w_tx_load    = 8'hFE;
            w_rd_go      = 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt < NAC_L) begin
            w_cnt_next = r_cnt + 10'd1;
          end else begin
            w_state_next = S_TOKEN;
            w_tx_load    = 8'hFE;
            w_rd_go      = 1'b1;
          end
        end
        S_TOKEN: begin
          w_state_next = S_DATA;
          w_tx_load    = r_hold;
          w_rd_go      = 1'b1;
          w_rd_idx     = 9'd1;
          w_cnt_next   = 10'd1;
        end
        S_DATA: begin
          if (r_cnt < 10'd512) begin
            w_tx_load  = r_hold;
            w_rd_go    = r_cnt < 10'd511;
            w_rd_idx   = r_cnt[8:0] + 9'd1;
            w_cnt_next = r_cnt + 10'd1;
          end else begin
            w_state_next = S_CRC16;
            w_tx_load    = w_crc_hi;
            w_cnt_next   = 10'd1;
          end
        end
        S_CRC16: begin
          if (r_cnt < 10'd2) begin
            w_tx_load  = w_crc_lo;
            w_cnt_next = 10'd2;
          end else begin
            w_state_next = S_HUNT;
          end
        end
        default: w_state_next = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sclk_sync  <= 2'b00;
      r_cs_sync    <= 2'b11;
      r_mosi_sync  <= 2'b11;
      r_sclk_prev  <= 1'b0;
      r_bit_cnt    <= 3'd0;
      r_rx         <= 7'h7F;
      r_tx         <= 8'hFF;
      r_hold       <= 8'hFF;
      r_cnt        <= 10'd0;
      r_idx        <= 6'd0;
      r_arg        <= 32'd0;
      r_trail      <= 32'hFFFF_FFFF;
      r_trail_n    <= 3'd0;
      r_r1         <= 8'hFF;
      r_data_go    <= 1'b0;
      r_blk        <= '0;
      r_idle       <= 1'b1;
      r_app        <= 1'b0;
      r_polls      <= 8'd0;
      o_card_ready <= 1'b0;
      o_cmd_strobe <= 1'b0;
      o_cmd_index  <= 6'd0;
      o_mem_rd     <= 1'b0;
      o_mem_addr   <= '0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[0], i_spi_sclk};
      r_cs_sync    <= {r_cs_sync[0], i_spi_cs};
      r_mosi_sync  <= {r_mosi_sync[0], i_spi_mosi};
      r_sclk_prev  <= r_sclk_sync[1];
      r_cnt        <= w_cnt_next;
      o_mem_rd     <= 1'b0;
      o_cmd_strobe <= 1'b0;
      if (o_mem_rd) r_hold <= i_mem_data;
      if (w_cs_hi) begin
        r_bit_cnt <= 3'd0;
        r_tx      <= 8'hFF;
      end else begin
        if (w_rise) begin
          r_rx      <= w_rx_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        // No shift on the fall that follows a boundary: the freshly loaded MSB must stay put
        if (w_boundary)                     r_tx <= w_tx_load;
        else if (w_fall && r_bit_cnt != 0)  r_tx <= {r_tx[6:0], 1'b1};
        if (w_boundary && r_state == S_HUNT) r_idx <= w_rx_byte[5:0];
        if (w_boundary && r_state == S_ARG)  r_arg <= {r_arg[23:0], w_rx_byte};
        if (w_strobe) begin
          o_cmd_strobe <= 1'b1;
          o_cmd_index  <= r_idx;
          r_r1         <= w_r1;
          r_trail      <= w_trail;
          r_trail_n    <= w_trail_n;
          r_data_go    <= w_data_go;
          r_blk        <= w_blk_full[BLK_W-1:0];
          r_idle       <= w_idle_nx;
          r_app        <= w_app_nx;
          r_polls      <= w_polls_nx;
          o_card_ready <= w_ready_nx;
        end
        if (w_resp_shift) r_trail <= {r_trail[23:0], 8'hFF};
        if (w_rd_go) begin
          o_mem_rd   <= 1'b1;
          o_mem_addr <= {r_blk, w_rd_idx};
        end
      end
    end
  end

`ifdef SD_MODEL_CRC16_EN
  logic [15:0] r_crc, w_crc_step;

  always_comb begin
    w_crc_step = r_crc;
    for (int i = 7; i >= 0; i--)
      w_crc_step = (w_crc_step[15] ^ r_hold[i]) ? ({w_crc_step[14:0], 1'b0} ^ 16'h1021)
                                                : {w_crc_step[14:0], 1'b0};
  end

  // Folded in as each data byte moves from the holding register to the shifter
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)
      r_crc <= 16'h0000;
    else if (w_boundary && (r_state == S_TOKEN || (r_state == S_DATA && r_cnt < 10'd512)))
      r_crc <= w_crc_step;
    else if (r_state != S_TOKEN && r_state != S_DATA && r_state != S_CRC16)
      r_crc <= 16'h0000;
  end

  assign w_crc_hi = r_crc[15:8];
  assign w_crc_lo = r_crc[7:0];
`else
  assign w_crc_hi = 8'hFF;
  assign w_crc_lo = 8'hFF;
`endif

endmodule

// File: tb/tb_sd_spi_card_model.sv
// tb/tb_sd_spi_card_model.sv - scoreboard bench: SPI host driver, miso/memory monitors, card behaviour model
module tb_sd_spi_card_model;
  localparam int ADDR_W     = 20;
  localparam int NCR        = 1;
  localparam int NAC        = 2;
  localparam int IDLE_POLLS = 2;
  localparam int SDHC       = 1;
  localparam int NBLK       = 1 << (ADDR_W - 9);
  localparam int H          = 4;

  logic clock = 1'b0, reset_n = 1'b0;
  logic spi_cs = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b1;
  logic spi_miso, mem_rd, card_ready, cmd_strobe;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_data = 8'h00;
  logic [5:0] cmd_index;

  int n_tests = 0, n_fail = 0;
  int rd_count = 0, strobe_count = 0;
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  bit m_idle = 1'b1, m_app = 1'b0, m_ready = 1'b0;
  int m_polls = 0;

  always #5 clock = ~clock;

  sd_spi_card_model #(.ADDR_W(ADDR_W), .NCR(NCR), .NAC(NAC), .IDLE_POLLS(IDLE_POLLS), .SDHC(SDHC)) dut (
    .i_clock(clock), .i_reset_n(reset_n), .i_spi_cs(spi_cs), .i_spi_sclk(spi_sclk),
    .i_spi_mosi(spi_mosi), .o_spi_miso(spi_miso), .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
    .i_mem_data(mem_data), .o_card_ready(card_ready), .o_cmd_strobe(cmd_strobe),
    .o_cmd_index(cmd_index)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Backing memory and read-address scoreboard
  always @(negedge clock) begin
    if (mem_rd) begin
      rd_count++;
      mem_data = mem_addr[7:0] ^ 8'h5A;
      if (addr_q.size() == 0) fail_now("mem_rd_unexpected");
      else check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
    end
    if (cmd_strobe) strobe_count++;
  end

  // miso byte monitor: host-side sample on every sclk rise
  initial begin : miso_mon
    logic [7:0] sh;
    int nb;
    sh = 8'h00;
    nb = 0;
    forever begin
      @(posedge spi_sclk);
      if (!spi_cs) begin
        sh = {sh[6:0], spi_miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) fail_now("miso_byte_unexpected");
          else check("miso_byte", 32'(sh), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic xfer(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      tick(H);
      spi_sclk = 1'b1;
      tick(H);
      spi_sclk = 1'b0;
    end
  endtask

  // abort_after < 0: complete transaction; otherwise stop after that many data bytes
  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input int abort_after);
    logic [7:0]  r1, d;
    logic [7:0]  e[$];
    logic [7:0]  tr[$];
    logic [7:0]  cmd[6];
    logic [31:0] blk;
    logic [15:0] crc;
    logic [ADDR_W-1:0] a;
    bit data;
    int s0, rc;

    r1   = {7'd0, m_idle};
    data = 1'b0;
    blk  = (SDHC != 0) ? arg : (arg >> 9);
    case (idx)
      6'd0:  begin m_idle = 1'b1; m_ready = 1'b0; m_polls = 0; r1 = 8'h01; end
      6'd8:  tr = '{8'h00, 8'h00, {4'h0, arg[11:8]}, arg[7:0]};
      6'd55: ;
      6'd41: begin
        if (!m_app) r1 = 8'h04 | {7'd0, m_idle};
        else if (m_polls < IDLE_POLLS) begin r1 = 8'h01; m_polls++; end
        else begin m_idle = 1'b0; m_ready = 1'b1; r1 = 8'h00; end
      end
      6'd58: tr = (SDHC != 0) ? '{8'hC0, 8'hFF, 8'h80, 8'h00} : '{8'h80, 8'hFF, 8'h80, 8'h00};
      6'd17: begin
        if (m_idle)           r1 = 8'h05;
        else if (blk >= NBLK) r1 = 8'h20;
        else                  data = 1'b1;
      end
      default: r1 = 8'h04 | {7'd0, m_idle};
    endcase
    m_app = (idx == 6'd55);

    repeat (6 + NCR) e.push_back(8'hFF);
    e.push_back(r1);
    foreach (tr[k]) e.push_back(tr[k]);
    if (data) begin
      repeat (NAC) e.push_back(8'hFF);
      e.push_back(8'hFE);
      crc = 16'h0000;
      for (int k = 0; k < 512; k++) begin
        a = ADDR_W'(blk * 512 + k);
        d = a[7:0] ^ 8'h5A;
        e.push_back(d);
        crc = crc16_byte(crc, d);
        addr_q.push_back(a);
      end
`ifdef SD_MODEL_CRC16_EN
      e.push_back(crc[15:8]);
      e.push_back(crc[7:0]);
`else
      e.push_back(8'hFF);
      e.push_back(8'hFF);
`endif
    end
    if (abort_after >= 0) begin
      while (e.size() > 6 + NCR + 1 + NAC + 1 + abort_after) void'(e.pop_back());
    end else begin
      repeat (2) e.push_back(8'hFF);
    end
    foreach (e[k]) exp_q.push_back(e[k]);

    cmd = '{{2'b01, idx}, arg[31:24], arg[23:16], arg[15:8], arg[7:0],
            (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'hFF};
    s0 = strobe_count;
    spi_cs = 1'b0;
    tick(4);
    for (int k = 0; k < e.size(); k++) xfer((k < 6) ? cmd[k] : 8'hFF);
    tick(4);
    if (abort_after >= 0) begin
      rc = rd_count;
      spi_cs = 1'b1;
      tick(3);
      check("miso_after_cs_high", 32'(spi_miso), 32'd1);
      tick(200);
      check("no_mem_rd_after_abort", 32'(rd_count), 32'(rc));
      addr_q.delete();
    end else begin
      spi_cs = 1'b1;
      tick(8);
    end
    check("cmd_strobe_pulses", 32'(strobe_count - s0), 32'd1);
    check("cmd_index", 32'(cmd_index), 32'(idx));
    check("card_ready", 32'(card_ready), 32'(m_ready));
    check("miso_bytes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stim
    logic [5:0] other[8];
    int rd0;
    other = '{6'd1, 6'd9, 6'd10, 6'd12, 6'd13, 6'd16, 6'd24, 6'd59};

    tick(3);
    check("reset_miso", 32'(spi_miso), 32'd1);
    check("reset_mem_rd", 32'(mem_rd), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_card_ready", 32'(card_ready), 32'd0);
    check("reset_cmd_strobe", 32'(cmd_strobe), 32'd0);
    check("reset_cmd_index", 32'(cmd_index), 32'd0);
    reset_n = 1'b1;
    tick(4);

    do_cmd(6'd0, 32'd0, -1);
    do_cmd(6'd8, 32'h0000_01AA, -1);
    do_cmd(6'd8, $urandom, -1);
    do_cmd(other[$urandom_range(0, 7)], $urandom, -1);
    do_cmd(6'd41, 32'h4000_0000, -1);
    do_cmd(6'd17, 32'd3, -1);
    for (int r = 0; r < 3; r++) begin
      do_cmd(6'd55, 32'd0, -1);
      do_cmd(6'd41, 32'h4000_0000, -1);
    end
    do_cmd(6'd58, 32'd0, -1);

    rd0 = rd_count;
    do_cmd(6'd17, 32'd3, -1);
    check("block_read_mem_rd_pulses", 32'(rd_count - rd0), 32'd512);
    check("block_read_addr_drained", 32'(addr_q.size()), 32'd0);

    do_cmd(6'd17, 32'(NBLK), -1);
    do_cmd(6'd17, 32'(NBLK) + $urandom_range(1, 100000), -1);
    do_cmd(other[$urandom_range(0, 7)], $urandom, -1);
    do_cmd(6'd17, 32'($urandom_range(0, NBLK - 1)), 100);
    do_cmd(6'd0, 32'd0, -1);
    do_cmd(6'd17, 32'd5, -1);

    check("final_addr_queue_empty", 32'(addr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
